// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUControl encodings and the arbiter FSM state type.
package alu_pkg;

  localparam logic [2:0] ALU_OP_AND = 3'b000;
  localparam logic [2:0] ALU_OP_OR  = 3'b001;
  localparam logic [2:0] ALU_OP_ADD = 3'b010;
  localparam logic [2:0] ALU_OP_SUB = 3'b110;
  localparam logic [2:0] ALU_OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational single-cycle ALU (AND/OR/ADD/SUB/signed SLT) with Zero flag.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] S1,
  input  logic [WIDTH-1:0] S2,
  input  logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);

  always_comb begin
    // NOTE: default assignment first so every path drives ALUResult; no latch is inferred.
    ALUResult = '0;
    case (ALUControl)
      ALU_OP_AND: ALUResult = S1 & S2;
      ALU_OP_OR:  ALUResult = S1 | S2;
      ALU_OP_ADD: ALUResult = S1 + S2;
      ALU_OP_SUB: ALUResult = S1 - S2;
      ALU_OP_SLT: ALUResult = {{(WIDTH-1){1'b0}}, ($signed(S1) < $signed(S2))};
      default:    ALUResult = '0;
    endcase
  end

  assign Zero = (ALUResult == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one ALU: IDLE accepts, EXEC computes,
// RESP holds the registered result until the granted requester consumes it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_s1,
  input  logic [WIDTH-1:0] req0_s2,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_s1,
  input  logic [WIDTH-1:0] req1_s2,
  input  logic [2:0]       req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             busy,
  output logic [15:0]      op_count
);

  arb_state_e       state_q, state_d;
  logic [WIDTH-1:0] s1_q, s2_q, result_q, alu_result;
  logic [2:0]       op_q;
  logic             gnt_q, last_q, zero_q, alu_zero;
  logic [15:0]      count_q;
  logic             accept, accept_idx, rsp_fire;

  // On a tie the requester that did not win the previous accept is served.
  assign req0_ready = (state_q == IDLE) && req0_valid && (!req1_valid || last_q);
  assign req1_ready = (state_q == IDLE) && req1_valid && (!req0_valid || !last_q);
  assign accept     = req0_ready || req1_ready;
  assign accept_idx = req1_ready;

  assign rsp0_valid = (state_q == RESP) && !gnt_q;
  assign rsp1_valid = (state_q == RESP) && gnt_q;
  assign rsp_fire   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      result_q <= '0;
      zero_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        gnt_q  <= accept_idx;
        last_q <= accept_idx;
      end
      if (state_q == EXEC) begin
        result_q <= alu_result;
        zero_q   <= alu_zero;
      end
      if (rsp_fire) count_q <= count_q + 16'd1;
    end
  end

  // NOTE: operand registers carry no reset; they are always loaded on accept before EXEC reads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_q <= accept_idx ? req1_s1 : req0_s1;
      s2_q <= accept_idx ? req1_s2 : req0_s2;
      op_q <= accept_idx ? req1_op : req0_op;
    end
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .S1        (s1_q),
    .S2        (s2_q),
    .ALUControl(op_q),
    .ALUResult (alu_result),
    .Zero      (alu_zero)
  );

  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign busy       = (state_q != IDLE);
  assign op_count   = count_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width passed to the shared ALU.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports reqK_valid  input  1  requester K (K=0,1) presents an operation.
REQ-005 SHALL have ports reqK_ready  output  1  arbiter accepts requester K this cycle.
REQ-006 SHALL have ports reqK_s1, reqK_s2  input  WIDTH  operands of requester K.
REQ-007 SHALL have ports reqK_op  input  3  ALUControl code of requester K.
REQ-008 SHALL have ports rspK_valid  output  1  result for requester K is available.
REQ-009 SHALL have ports rspK_ready  input  1  requester K consumes its result.
REQ-010 SHALL have ports rsp_result  output  WIDTH, rsp_zero  output  1  shared result bus and Zero flag, meaningful when either rspK_valid is high.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port op_count  output  16  count of completed response handshakes.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-014 SHALL, in IDLE only, assert reqK_ready combinationally for the granted requester, where grant = the sole valid requester, or, if both are valid, the requester not granted last (round robin).
REQ-015 SHALL, on an accept edge (reqK_valid & reqK_ready), register s1, s2, op and the grant index, and move IDLE->EXEC.
REQ-016 SHALL drive the ALU S1/S2/ALUControl from the registered operands only, never directly from request ports.
REQ-017 SHALL, at the EXEC->RESP edge, capture ALUResult and Zero into rsp_result/rsp_zero and move to RESP; accept-to-rspK_valid latency is exactly 2 cycles.
REQ-018 SHALL, in RESP, hold rspK_valid high for the granted K only, with rsp_result/rsp_zero stable, until rspK_ready is sampled high; then return to IDLE and increment op_count (wraps 16'hFFFF->0).
REQ-019 SHALL keep the non-granted rsp valid low and both reqK_ready low in EXEC and RESP.
REQ-020 SHALL update the last-grant flag only on accept; a requester dropping valid before accept has no effect on it.
REQ-021 SHALL give minimum throughput of one operation per 3 cycles (accept, EXEC, RESP with immediate rsp_ready); no accept in the same cycle as a response handshake.
REQ-022 SHALL tolerate requesters changing operands while not accepted; only values at the accept edge are used.

Reset
REQ-023 SHALL, on reset_n low, immediately set state IDLE, last-grant = 1 (requester 0 wins first tie), op_count 0, rsp_result 0, rsp_zero 0, all rspK_valid 0, busy 0.
REQ-024 SHALL abandon any in-flight operation on reset mid-EXEC or mid-RESP with no response delivered.

Structure
REQ-025 SHALL take ALU op encodings from shared package alu_pkg: ALU_OP_AND=3'b000, ALU_OP_OR=3'b001, ALU_OP_ADD=3'b010, ALU_OP_SUB=3'b110, ALU_OP_SLT=3'b111; the FSM state type also lives there.
REQ-026 SHALL instantiate exactly one existing ALU module as its only sub-module; no second arithmetic path.

Verification
REQ-027 Single request: req0 ADD s1=32'h0FFF1234 s2=32'h0FFF4321, rsp0_ready=1 -> rsp0_valid 2 cycles after accept, rsp_result=32'h1FFE5555, rsp_zero=0, op_count=1.
REQ-028 Tie: both valid from reset, req0 SUB 5-5, req1 OR 32'hF0,32'h0F -> req0 first (result 0, rsp_zero=1), then req1 (result 32'hFF); next tie grants req0.
REQ-029 Backpressure: rsp1_ready low 5 cycles in RESP -> rsp1_valid and rsp_result held, reqK_ready low throughout, busy=1.
REQ-030 Reset mid-EXEC: assert reset_n low during EXEC -> all outputs reset values immediately, no rsp valid afterwards, op_count=0.
REQ-031 Back-to-back: req1 held valid with SLT 32'hFFFFFFFF,1 -> result 1, accepts spaced exactly 3 cycles; op_count wrap from 16'hFFFF to 0 checked via forced preload.
